game_state_keeper: RTL

- Responder to the game controller's `game_state_en`/`sel` command strobe.
- Holds the live 134-bit game state {way[63:0], box[63:0], man[5:0]}, which the controller, move logic and display consume.
- Keeps a ring-buffer undo history so the player can retract moves.
- Loads the level's initial state on retry or stage change.

---
 rtl/game_pkg.sv | 26 ++
 rtl/history_ram.sv | 25 ++
 rtl/game_state_keeper.sv | 123 ++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the game datapath: state layout, command codes and
// the state keeper FSM encoding.
package game_pkg;

  localparam int unsigned MAN_W   = 6;
  localparam int unsigned MAP_W   = 64;
  localparam int unsigned STATE_W = MAP_W + MAP_W + MAN_W;

  // Command codes carried on sel alongside game_state_en
  localparam logic [1:0] CMD_LOAD    = 2'b00;
  localparam logic [1:0] CMD_MOVE    = 2'b01;
  localparam logic [1:0] CMD_RETRACT = 2'b10;
  localparam logic [1:0] CMD_HOLD    = 2'b11;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StPopRd = 2'b01,
    StPopWr = 2'b10
  } keeper_state_e;

  // Player position field of a packed {way, box, man} state
  function automatic logic [MAN_W-1:0] state_man(input logic [STATE_W-1:0] s);
    return s[MAN_W-1:0];
  endfunction

endpackage

// File: rtl/history_ram.sv
// Undo history storage: single-port RAM, synchronous read, no reset so it
// maps onto block RAM.
module history_ram #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4,
  parameter int unsigned SW    = 134
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [SW-1:0] wdata,
  output logic [SW-1:0] rdata
);

  logic [SW-1:0] mem [DEPTH];

  // Write on enable; registered read of the same address every cycle
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/game_state_keeper.sv
// Live game state register with a ring-buffer undo history. Commands arrive
// as a one-cycle strobe; a retract runs a three-edge pop through the RAM.
module game_state_keeper
  import game_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4,
  parameter int unsigned SW    = STATE_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          game_state_en,
  input  logic [1:0]    sel,
  input  logic [SW-1:0] level_state,
  input  logic [SW-1:0] next_state,
  output logic [SW-1:0] game_state,
  output logic [AW:0]   hist_count,
  output logic          hist_empty,
  output logic          busy
);

  localparam logic [AW:0]   HistFull = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CountOne = (AW+1)'(1);
  localparam logic [AW-1:0] PtrOne   = AW'(1);

  keeper_state_e state_q, state_d;
  logic [SW-1:0] game_state_q, game_state_d;
  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] wp_q, wp_d;

  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [SW-1:0] ram_rdata;

  history_ram #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .SW    (SW)
  ) u_history_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (game_state_q),
    .rdata (ram_rdata)
  );

  // Command decode, pointer/count bookkeeping and retract sequencing
  always_comb begin
    state_d      = state_q;
    game_state_d = game_state_q;
    count_d      = count_q;
    wp_d         = wp_q;
    ram_we       = 1'b0;
    // Outside the retract strobe the RAM sits on wp, which after the
    // decrement is the entry being popped, so read data stays stable.
    ram_addr     = wp_q;

    unique case (state_q)
      StIdle: begin
        if (game_state_en) begin
          unique case (sel)
            CMD_LOAD: begin
              game_state_d = level_state;
              count_d      = '0;
              wp_d         = '0;
            end
            CMD_MOVE: begin
              ram_we       = 1'b1;
              wp_d         = wp_q + PtrOne;
              game_state_d = next_state;
              if (count_q != HistFull) begin
                count_d = count_q + CountOne;
              end
            end
            CMD_RETRACT: begin
              if (count_q != '0) begin
                wp_d     = wp_q - PtrOne;
                ram_addr = wp_q - PtrOne;
                state_d  = StPopRd;
              end
            end
            default: ;
          endcase
        end
      end
      StPopRd: begin
        state_d = StPopWr;
      end
      StPopWr: begin
        game_state_d = ram_rdata;
        count_d      = count_q - CountOne;
        state_d      = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State, pointer and count registers with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      game_state_q <= '0;
      count_q      <= '0;
      wp_q         <= '0;
    end else begin
      state_q      <= state_d;
      game_state_q <= game_state_d;
      count_q      <= count_d;
      wp_q         <= wp_d;
    end
  end

  // Output mapping
  always_comb begin
    game_state = game_state_q;
    hist_count = count_q;
    hist_empty = (count_q == '0);
    busy       = (state_q != StIdle);
  end

endmodule
